cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Miss-refill controller sitting directly downstream of the direct-mapped cache. It accepts one miss at a time from the cache and issues a single block-read request to next-level memory. It forwards the returned words to the cache data array as indexed fill writes and signals completion or timeout-abort. It also keeps a saturating count of completed refills.

## Interface
- ADDR_W, 32, byte-address width
- BLOCK_WORDS, 4, 32-bit words per cache block; power of two, ≥2
- TIMEOUT, 64, consecutive beat-less WAIT cycles before abort; ≥2
- CNT_W, 32, refill counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- miss_valid  in  1  cache presents a miss
- miss_ready  out  1  controller can accept a miss
- miss_addr  in  ADDR_W  byte address of the missing access
- mem_req_valid  out  1  block-read request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  block-aligned byte address
- mem_rsp_valid  in  1  one data beat this cycle, in word order 0..BLOCK_WORDS-1
- mem_rsp_data  in  32  beat data
- fill_valid  out  1  write fill_data into cache block
- fill_addr  out  ADDR_W  block-aligned byte address of the fill
- fill_idx  out  log2(BLOCK_WORDS)  word index within block
- fill_data  out  32  word to write
- fill_done  out  1  one-cycle pulse with final beat; cache sets valid/tag
- fill_abort  out  1  one-cycle pulse on timeout; cache must not set valid
- err_timeout  out  1  sticky, cleared only by reset
- refill_count  out  CNT_W  completed refills, saturating
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: miss_ready=1. On miss_valid, latch miss_addr with its low log2(BLOCK_WORDS)+2 bits zeroed; go to REQ.
- REQ: mem_req_valid=1, mem_req_addr=latched address. Hold until mem_req_ready, then go to WAIT with beat counter=0 and timer=0.
- WAIT, beat with mem_rsp_valid=1: register a fill (data, idx=beat counter, fill_addr=latched address); increment the beat counter; clear the timer.
  - If this is beat BLOCK_WORDS-1, go to DONE.
- WAIT, no beat: timer+1. When the timer would reach TIMEOUT, go to IDLE. Same edge: fill_abort=1 for one cycle, err_timeout=1. refill_count is unchanged.
- DONE: fill_done=1 for one cycle, concurrent with the last fill_valid. refill_count+1, saturating at 2^CNT_W-1. Go to IDLE.
- mem_rsp_valid outside WAIT is ignored, with no fill and no state change.
- miss_valid outside IDLE is ignored; miss_ready=0 means the cache must hold.
- Reset values: state=IDLE, all counters 0, fill_valid/fill_done/fill_abort/mem_req_valid/err_timeout/busy=0, fill_* data fields 0, refill_count=0. miss_ready=1 from the first cycle after reset.
- Reset asserted mid-refill returns to IDLE on that edge with no fill_done and no fill_abort.

## Timing
- miss_ready, mem_req_valid and busy are decoded from state. Fill outputs are registered.
- Miss accepted at edge T gives mem_req_valid=1 in cycle T+1.
- With mem_req_ready=1 in cycle T+1, WAIT is entered at T+2.
- Beat in cycle B gives fill_valid in cycle B+1.
- Last beat in cycle L gives fill_valid, fill_idx=BLOCK_WORDS-1 and fill_done all in cycle L+1, with state DONE.
- Cycle L+2: state IDLE, miss_ready=1, refill_count updated.
- Back-to-back beats give back-to-back fill_valid cycles. Gaps between beats are allowed.
- Minimum miss-to-miss spacing with zero memory wait is BLOCK_WORDS+3 cycles.

## Test plan
- Reset then idle: after rst_n is released, miss_ready=1, busy=0, refill_count=0, all pulses 0.
- Basic refill: miss_addr=0x0000_1234, mem_req_ready=1 immediately, 4 consecutive beats 0xA0..0xA3 -> mem_req_addr=0x0000_1230. fill_idx 0..3 carry data A0..A3 on 4 consecutive cycles. fill_done with idx 3, refill_count=1.
- Backpressure and gaps: mem_req_ready low for 5 cycles, then beats with 2-cycle gaps -> mem_req_valid is held steady. Fills are emitted in order, one per beat, with no extra pulses.
- Timeout: after request acceptance, 1 beat then 64 beat-less cycles -> fill_abort pulses once, err_timeout=1, no fill_done, refill_count unchanged, IDLE on the next cycle.
- Protocol robustness: mem_rsp_valid in IDLE, and miss_valid during WAIT -> both are ignored. A new miss is accepted only once IDLE is re-entered.
- Mid-refill reset and saturation: reset during WAIT -> IDLE with no pulses. With CNT_W=2, 5 refills -> refill_count stays at 3.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: takes one cache miss, issues a block read to memory,
// and streams the returned beats back to the cache as indexed fill writes.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_valid,
  output logic                           miss_ready,
  input  logic [ADDR_W-1:0]              miss_addr,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic [ADDR_W-1:0]              mem_req_addr,
  input  logic                           mem_rsp_valid,
  input  logic [31:0]                    mem_rsp_data,
  output logic                           fill_valid,
  output logic [ADDR_W-1:0]              fill_addr,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
  output logic [31:0]                    fill_data,
  output logic                           fill_done,
  output logic                           fill_abort,
  output logic                           err_timeout,
  output logic [CNT_W-1:0]               refill_count,
  output logic                           busy
);

  localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] blk_addr;
  logic [IDX_W-1:0]  beat_cnt;
  logic [TMR_W-1:0]  timer;

  // Handshake outputs are pure decodes of the registered state.
  assign miss_ready    = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign busy          = (state != IDLE);
  assign mem_req_addr  = blk_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      blk_addr     <= '0;
      beat_cnt     <= '0;
      timer        <= '0;
      fill_valid   <= 1'b0;
      fill_addr    <= '0;
      fill_idx     <= '0;
      fill_data    <= '0;
      fill_done    <= 1'b0;
      fill_abort   <= 1'b0;
      err_timeout  <= 1'b0;
      refill_count <= '0;
    end else begin
      fill_valid <= 1'b0;
      fill_done  <= 1'b0;
      fill_abort <= 1'b0;

      case (state)
        IDLE: begin
          if (miss_valid) begin
            blk_addr <= miss_addr & ~OFF_MASK;
            state    <= REQ;
          end
        end

        REQ: begin
          if (mem_req_ready) begin
            beat_cnt <= '0;
            timer    <= '0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          // A beat always wins over the timeout on the same cycle.
          if (mem_rsp_valid) begin
            fill_valid <= 1'b1;
            fill_addr  <= blk_addr;
            fill_idx   <= beat_cnt;
            fill_data  <= mem_rsp_data;
            beat_cnt   <= beat_cnt + IDX_W'(1);
            timer      <= '0;
            if (beat_cnt == LAST_BEAT) begin
              fill_done <= 1'b1;
              state     <= DONE;
            end
          end else if (timer == TMR_LAST) begin
            fill_abort  <= 1'b1;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        DONE: begin
          if (refill_count != '1) begin
            refill_count <= refill_count + CNT_W'(1);
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: driver pushes expected requests and
// fill events into queues, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 2;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_valid;
  logic          miss_ready;
  logic [AW-1:0] miss_addr;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic [1:0]    fill_idx;
  logic [31:0]   fill_data;
  logic          fill_done;
  logic          fill_abort;
  logic          err_timeout;
  logic [CW-1:0] refill_count;
  logic          busy;

  cache_refill_ctrl #(
    .ADDR_W(AW), .BLOCK_WORDS(BW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_idx(fill_idx), .fill_data(fill_data),
    .fill_done(fill_done), .fill_abort(fill_abort), .err_timeout(err_timeout),
    .refill_count(refill_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        abort;
    logic [31:0] addr;
    logic [1:0]  idx;
    logic [31:0] data;
  } fill_ev_t;

  fill_ev_t    fill_q[$];
  logic [31:0] req_q[$];
  fill_ev_t    mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned model_cnt = 0;

  function automatic logic [31:0] blk(input logic [31:0] a);
    return a & ~(32'(BW * 4) - 32'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fill/done/abort output must match the next expected event.
  always @(negedge clk) begin
    if (fill_valid === 1'b1 || fill_done === 1'b1 || fill_abort === 1'b1) begin
      if (fill_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fill: got valid=%b done=%b abort=%b idx=%0d, expected no event at %0t",
                 fill_valid, fill_done, fill_abort, fill_idx, $time);
      end else begin
        mon_e = fill_q.pop_front();
        chk("fill_valid", 64'(fill_valid), 64'(mon_e.valid));
        chk("fill_done",  64'(fill_done),  64'(mon_e.done));
        chk("fill_abort", 64'(fill_abort), 64'(mon_e.abort));
        if (mon_e.valid) begin
          chk("fill_addr", 64'(fill_addr), 64'(mon_e.addr));
          chk("fill_idx",  64'(fill_idx),  64'(mon_e.idx));
          chk("fill_data", 64'(fill_data), 64'(mon_e.data));
        end
      end
    end
    if (mem_req_valid === 1'b1) begin
      if (req_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got addr 0x%0h, expected no request at %0t", mem_req_addr, $time);
      end else begin
        chk("mem_req_addr", 64'(mem_req_addr), 64'(req_q[0]));
        if (mem_req_ready) void'(req_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_miss(input logic [31:0] a);
    int n = 0;
    while (miss_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("miss_ready_before_miss", 64'(miss_ready), 64'd1);
    miss_valid = 1'b1;
    miss_addr  = a;
    req_q.push_back(blk(a));
    step();
    miss_valid = 1'b0;
    chk("req_latency", 64'(mem_req_valid), 64'd1);
  endtask

  // Stall the request, wiggling mem_rsp_valid (must be ignored in REQ).
  task automatic handshake(input int stall);
    mem_req_ready = 1'b0;
    repeat (stall) begin
      mem_rsp_valid = 1'($urandom_range(1, 0));
      mem_rsp_data  = $urandom;
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("wait_req_valid", 64'(mem_req_valid), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
  endtask

  task automatic send_beats(input logic [31:0] a, input int n, input logic [31:0] base,
                            input int gap_lo, input int gap_hi);
    fill_ev_t e;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) step();
      d = (base != 32'd0) ? base + 32'(i) : $urandom;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      e = '{valid: 1'b1, done: (i == BW - 1), abort: 1'b0, addr: blk(a), idx: 2'(i), data: d};
      fill_q.push_back(e);
      step();
      mem_rsp_valid = 1'b0;
      chk("fill_latency", 64'(fill_valid), 64'd1);
      if (i == BW - 1) chk("done_with_last", 64'(fill_done), 64'd1);
    end
  endtask

  task automatic finish_refill();
    step();
    model_cnt = (model_cnt < CNT_MAX) ? model_cnt + 1 : model_cnt;
    chk("idle_miss_ready", 64'(miss_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("refill_count", 64'(refill_count), 64'(model_cnt));
  endtask

  task automatic timeout_tail();
    fill_ev_t e;
    e = '{valid: 1'b0, done: 1'b0, abort: 1'b1, addr: 32'd0, idx: 2'd0, data: 32'd0};
    fill_q.push_back(e);
    repeat (TO) @(posedge clk);
    #1;
    chk("abort_pulse", 64'(fill_abort), 64'd1);
    chk("err_timeout", 64'(err_timeout), 64'd1);
    chk("abort_idle", 64'(miss_ready), 64'd1);
    chk("abort_count", 64'(refill_count), 64'(model_cnt));
  endtask

  task automatic full_refill(input logic [31:0] a, input int stall, input int gap_hi);
    issue_miss(a);
    handshake(stall);
    send_beats(a, BW, 32'd0, 0, gap_hi);
    finish_refill();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int nb;
    rst_n = 1'b0; miss_valid = 1'b0; miss_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_miss_ready", 64'(miss_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_count", 64'(refill_count), 64'd0);
    chk("rst_fill_valid", 64'(fill_valid), 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    chk("rst_fill_abort", 64'(fill_abort), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_fill_data", 64'(fill_data), 64'd0);

    // Basic refill with directed data
    issue_miss(32'h0000_1234);
    chk("basic_req_addr", 64'(mem_req_addr), 64'h0000_1230);
    handshake(0);
    send_beats(32'h0000_1234, BW, 32'h0000_00A0, 0, 0);
    finish_refill();

    // Backpressure and 2-cycle beat gaps
    a = $urandom;
    issue_miss(a);
    handshake(5);
    send_beats(a, BW, 32'd0, 2, 2);
    finish_refill();

    // Timeout after one beat
    a = $urandom;
    issue_miss(a);
    handshake(0);
    send_beats(a, 1, 32'd0, 0, 0);
    timeout_tail();

    // Stray response in IDLE is ignored
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = $urandom;
    repeat (3) step();
    mem_rsp_valid = 1'b0;
    chk("stray_rsp_busy", 64'(busy), 64'd0);

    // Miss presented during WAIT waits until IDLE
    a = $urandom;
    b = $urandom;
    issue_miss(a);
    handshake(1);
    miss_valid = 1'b1;
    miss_addr  = b;
    send_beats(a, BW, 32'd0, 0, 1);
    miss_valid = 1'b0;
    finish_refill();
    full_refill(b, 0, 0);

    // Largest beat gap that must not time out
    a = $urandom;
    issue_miss(a);
    handshake(0);
    send_beats(a, BW, 32'd0, TO - 1, TO - 1);
    finish_refill();
    chk("gap_no_new_err", 64'(err_timeout), 64'd1);

    // Randomized mix of refills and timeouts
    for (int t = 0; t < 30; t++) begin
      a = $urandom;
      if ($urandom_range(5, 0) == 0) begin
        nb = $urandom_range(BW - 1, 0);
        issue_miss(a);
        handshake($urandom_range(3, 0));
        send_beats(a, nb, 32'd0, 0, 3);
        timeout_tail();
      end else begin
        full_refill(a, $urandom_range(3, 0), 3);
      end
      repeat ($urandom_range(2, 0)) step();
    end

    // Reset in the middle of WAIT
    a = $urandom;
    issue_miss(a);
    handshake(0);
    send_beats(a, 1, 32'd0, 0, 0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_cnt = 0;
    chk("midrst_miss_ready", 64'(miss_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_count", 64'(refill_count), 64'd0);
    chk("midrst_err", 64'(err_timeout), 64'd0);
    chk("midrst_abort", 64'(fill_abort), 64'd0);
    repeat (TO + 5) step();
    chk("midrst_quiet_err", 64'(err_timeout), 64'd0);

    // Counter saturation at 2^CW-1
    for (int t = 0; t < 5; t++) full_refill($urandom, 0, 0);
    chk("sat_count", 64'(refill_count), 64'(CNT_MAX));

    repeat (3) step();
    chk("fill_q_empty", 64'(fill_q.size()), 64'd0);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
